// File: rtl/br_resolve.sv
// Branch resolution: turns a compare result into a direction, flags mispredicts and misaligned taken targets.
// Latency: one cycle; flush/exc_misalign/redirect are registered and appear the cycle after acceptance.
// Backpressure: in_ready drops while a redirect is pending; upstream must hold its descriptor until ack.
// Optional build macro BR_PERF_CNT_EN adds taken_cnt / mispred_cnt performance counters.
module br_resolve #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             cmp_true,
  input  logic             is_jump,
  input  logic             pred_taken,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] br_target,
  output logic             redirect_valid,
  output logic [WIDTH-1:0] redirect_pc,
  input  logic             redirect_ack,
  output logic             flush,
  output logic             exc_misalign,
  output logic [WIDTH-1:0] exc_pc
`ifdef BR_PERF_CNT_EN
  ,
  output logic [31:0]      taken_cnt,
  output logic [31:0]      mispred_cnt
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

  state_t           state_q, state_d;
  logic             flush_q, flush_d;
  logic             exc_q, exc_d;
  logic [WIDTH-1:0] exc_pc_q, exc_pc_d;
  logic [WIDTH-1:0] rpc_q, rpc_d;

  logic             accept;
  logic             taken;
  logic             mispred;
  logic             misalign;
  logic [WIDTH-1:0] fix_pc;
  logic             start_redirect;

  // Decode the incoming descriptor; only meaningful when accept is high.
  always_comb begin
    accept         = in_valid && (state_q == S_IDLE);
    taken          = is_jump | cmp_true;
    mispred        = taken ^ pred_taken;
    misalign       = taken && (br_target[1:0] != 2'b00);
    fix_pc         = taken ? br_target : (pc + PC_STEP);
    // A misaligned taken target traps instead of redirecting; the trap unit owns that flush.
    start_redirect = accept && !misalign && mispred;
  end

  // FSM state register; reset abandons any pending redirect without needing an ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: IDLE waits for a mispredict, REQ waits for fetch to ack.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_redirect) state_d = S_REQ;
      S_REQ:   if (redirect_ack)   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs are pure state decodes, so they come straight from the state flop.
  always_comb begin
    in_ready       = (state_q == S_IDLE);
    redirect_valid = (state_q == S_REQ);
  end

  // Next values for the registered pulses and held addresses.
  always_comb begin
    flush_d  = start_redirect;
    exc_d    = accept && misalign;
    exc_pc_d = exc_d ? pc : exc_pc_q;
    rpc_d    = start_redirect ? fix_pc : rpc_q;
  end

  // Output registers; redirect_pc only changes on a new redirect so it stays stable through REQ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_q  <= 1'b0;
      exc_q    <= 1'b0;
      exc_pc_q <= '0;
      rpc_q    <= '0;
    end else begin
      flush_q  <= flush_d;
      exc_q    <= exc_d;
      exc_pc_q <= exc_pc_d;
      rpc_q    <= rpc_d;
    end
  end

  assign flush        = flush_q;
  assign exc_misalign = exc_q;
  assign exc_pc       = exc_pc_q;
  assign redirect_pc  = rpc_q;

`ifdef BR_PERF_CNT_EN
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  // Counters include misaligned branches; they wrap naturally at 32 bits.
  always_comb begin
    taken_cnt_d   = taken_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (accept && taken)   taken_cnt_d   = taken_cnt_q + 32'd1;
    if (accept && mispred) mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      taken_cnt_q   <= '0;
      mispred_cnt_q <= '0;
    end else begin
      taken_cnt_q   <= taken_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign taken_cnt   = taken_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_br_resolve.sv
// Bench for br_resolve: directed test-plan sequences with literal expectations,
// then randomized traffic checked every cycle against a queue-based reference model.
module tb_br_resolve;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        cmp_true;
  logic        is_jump;
  logic        pred_taken;
  logic [31:0] pc;
  logic [31:0] br_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ack;
  logic        flush;
  logic        exc_misalign;
  logic [31:0] exc_pc;
`ifdef BR_PERF_CNT_EN
  logic [31:0] taken_cnt;
  logic [31:0] mispred_cnt;
`endif

  br_resolve #(.WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .cmp_true(cmp_true),
    .is_jump(is_jump),
    .pred_taken(pred_taken),
    .pc(pc),
    .br_target(br_target),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .redirect_ack(redirect_ack),
    .flush(flush),
    .exc_misalign(exc_misalign),
    .exc_pc(exc_pc)
`ifdef BR_PERF_CNT_EN
    ,
    .taken_cnt(taken_cnt),
    .mispred_cnt(mispred_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: a pending-redirect queue (at most one entry) plus expected pulses.
  logic [31:0] rq[$];
  logic [31:0] m_rpc = 32'h0;
  bit          m_flush = 1'b0;
  bit          m_exc = 1'b0;
  logic [31:0] m_exc_pc = 32'h0;
  logic [31:0] m_tcnt = 32'h0;
  logic [31:0] m_mcnt = 32'h0;
  bit          m_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    m_rpc = 32'h0;
    m_flush = 1'b0;
    m_exc = 1'b0;
    m_exc_pc = 32'h0;
    m_tcnt = 32'h0;
    m_mcnt = 32'h0;
    m_acc = 1'b0;
  endtask

  // Apply the branch rules to whatever the bench is driving at this clock edge.
  task automatic model_edge();
    bit          tk;
    bit          mp;
    logic [31:0] fix;
    m_acc   = in_valid && (rq.size() == 0);
    m_flush = 1'b0;
    m_exc   = 1'b0;
    if (rq.size() != 0) begin
      if (redirect_ack) rq.delete();
    end else if (m_acc) begin
      tk  = is_jump || cmp_true;
      mp  = (tk != pred_taken);
      fix = tk ? br_target : pc + 32'd4;
      if (tk) m_tcnt = m_tcnt + 32'd1;
      if (mp) m_mcnt = m_mcnt + 32'd1;
      if (tk && (br_target % 4) != 0) begin
        m_exc    = 1'b1;
        m_exc_pc = pc;
      end else if (mp) begin
        rq.push_back(fix);
        m_rpc   = fix;
        m_flush = 1'b1;
      end
    end
  endtask

  // One clock: the model observes the same edge as the DUT, then inputs may change.
  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      chk("cmp_in_ready", {31'h0, in_ready}, (rq.size() == 0) ? 32'h1 : 32'h0);
      chk("cmp_redirect_valid", {31'h0, redirect_valid}, (rq.size() != 0) ? 32'h1 : 32'h0);
      chk("cmp_redirect_pc", redirect_pc, m_rpc);
      chk("cmp_flush", {31'h0, flush}, {31'h0, m_flush});
      chk("cmp_exc_misalign", {31'h0, exc_misalign}, {31'h0, m_exc});
      if (m_exc) chk("cmp_exc_pc", exc_pc, m_exc_pc);
`ifdef BR_PERF_CNT_EN
      chk("cmp_taken_cnt", taken_cnt, m_tcnt);
      chk("cmp_mispred_cnt", mispred_cnt, m_mcnt);
`endif
    end
  end

  task automatic set_br(input logic v, input logic [31:0] p, input logic [31:0] t,
                        input logic c, input logic j, input logic pr);
    in_valid = v; pc = p; br_target = t; cmp_true = c; is_jump = j; pred_taken = pr;
  endtask

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    redirect_ack = 1'b0;
    set_br(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    chk("reset_in_ready", {31'h0, in_ready}, 32'h1);
    chk("reset_redirect_valid", {31'h0, redirect_valid}, 32'h0);
    chk("reset_redirect_pc", redirect_pc, 32'h0);
    chk("reset_flush", {31'h0, flush}, 32'h0);
    chk("reset_exc_misalign", {31'h0, exc_misalign}, 32'h0);
    chk("reset_exc_pc", exc_pc, 32'h0);
`ifdef BR_PERF_CNT_EN
    chk("reset_taken_cnt", taken_cnt, 32'h0);
    chk("reset_mispred_cnt", mispred_cnt, 32'h0);
`endif
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;

    // Not taken, predicted not taken: silent.
    set_br(1'b1, 32'h100, 32'h200, 1'b0, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("nt_flush", {31'h0, flush}, 32'h0);
    chk("nt_redirect_valid", {31'h0, redirect_valid}, 32'h0);
    chk("nt_in_ready", {31'h0, in_ready}, 32'h1);

    // Taken, predicted not taken: flush one cycle, redirect held until ack.
    set_br(1'b1, 32'h100, 32'h200, 1'b1, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("tk_flush", {31'h0, flush}, 32'h1);
    chk("tk_redirect_valid", {31'h0, redirect_valid}, 32'h1);
    chk("tk_redirect_pc", redirect_pc, 32'h200);
    tick();
    chk("tk_flush_once", {31'h0, flush}, 32'h0);
    tick();
    tick();
    chk("tk_hold_pc", redirect_pc, 32'h200);
    chk("tk_hold_in_ready", {31'h0, in_ready}, 32'h0);
    chk("tk_hold_valid", {31'h0, redirect_valid}, 32'h1);
    redirect_ack = 1'b1;
    tick();
    redirect_ack = 1'b0;
    chk("tk_ack_valid", {31'h0, redirect_valid}, 32'h0);
    chk("tk_ack_in_ready", {31'h0, in_ready}, 32'h1);

    // Not taken, predicted taken, fall-through wraps to zero.
    set_br(1'b1, 32'hFFFF_FFFC, 32'h400, 1'b0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("wrap_redirect_pc", redirect_pc, 32'h0);
    chk("wrap_redirect_valid", {31'h0, redirect_valid}, 32'h1);
    redirect_ack = 1'b1;
    tick();
    redirect_ack = 1'b0;

    // Misaligned jump: exception pulse, no redirect.
    set_br(1'b1, 32'h80, 32'h202, 1'b0, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("mis_exc", {31'h0, exc_misalign}, 32'h1);
    chk("mis_exc_pc", exc_pc, 32'h80);
    chk("mis_flush", {31'h0, flush}, 32'h0);
    chk("mis_redirect_valid", {31'h0, redirect_valid}, 32'h0);
    tick();
    chk("mis_exc_once", {31'h0, exc_misalign}, 32'h0);

    // Ack and a new mispredicted branch in the same REQ cycle.
    set_br(1'b1, 32'h300, 32'h400, 1'b1, 1'b0, 1'b0);
    tick();
    set_br(1'b1, 32'h500, 32'h600, 1'b0, 1'b0, 1'b1);
    redirect_ack = 1'b1;
    tick();
    redirect_ack = 1'b0;
    chk("sim_ack_valid", {31'h0, redirect_valid}, 32'h0);
    chk("sim_ack_in_ready", {31'h0, in_ready}, 32'h1);
    chk("sim_ack_flush", {31'h0, flush}, 32'h0);
    tick();
    in_valid = 1'b0;
    chk("sim_second_flush", {31'h0, flush}, 32'h1);
    chk("sim_second_pc", redirect_pc, 32'h504);
    chk("sim_second_valid", {31'h0, redirect_valid}, 32'h1);

    // Asynchronous reset in the middle of REQ.
    #1 reset = 1'b1;
    #1;
    chk("areset_redirect_valid", {31'h0, redirect_valid}, 32'h0);
    chk("areset_in_ready", {31'h0, in_ready}, 32'h1);
    chk("areset_redirect_pc", redirect_pc, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;

`ifdef BR_PERF_CNT_EN
    // Five branches as (taken, pred): (1,1) (1,0) (0,1) (0,0) (1,1).
    begin
      logic [9:0] pairs;
      pairs = 10'b11_10_01_00_11;
      for (int k = 0; k < 5; k++) begin
        set_br(1'b1, 32'h40, 32'h1000, pairs[9 - 2*k], 1'b0, pairs[8 - 2*k]);
        tick();
        in_valid = 1'b0;
        if (redirect_valid) begin
          redirect_ack = 1'b1;
          tick();
          redirect_ack = 1'b0;
        end
      end
      chk("perf_taken_cnt", taken_cnt, 32'd3);
      chk("perf_mispred_cnt", mispred_cnt, 32'd2);
    end
`endif

    // Randomized traffic; a stalled descriptor is held until it is accepted.
    for (int i = 0; i < 3000; i++) begin
      if (!(in_valid && !m_acc)) begin
        logic [31:0] p;
        logic [31:0] t;
        if ($urandom_range(0, 3) == 0) p = 32'hFFFF_FFF0 + {28'h0, 2'($urandom_range(0, 3)), 2'b00};
        else p = $urandom & 32'hFFFF_FFFC;
        t = $urandom;
        if ($urandom_range(0, 3) != 0) t = t & 32'hFFFF_FFFC;
        set_br($urandom_range(0, 9) < 7, p, t, 1'($urandom_range(0, 1)),
               $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)));
      end
      redirect_ack = ($urandom_range(0, 9) < 4);
      tick();
    end
    in_valid = 1'b0;
    redirect_ack = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/br_resolve.md
# br_resolve

Branch resolution stage in the execute pipeline, directly downstream of the compare unit. It consumes the compare unit's `true` result together with the branch descriptor latched by decode. It decides the actual branch direction, detects mispredictions against the static prediction made at fetch, and drives a held redirect request to fetch until fetch acknowledges it. Misaligned taken targets are reported as a one-cycle exception pulse instead of a redirect.

## Interface
- `WIDTH`, default 32: address/data width, same as the compare unit operand width.
- `clk`, input, 1: clock. All state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `in_valid`, input, 1: a branch or jump descriptor is present this cycle.
- `in_ready`, output, 1: the stage can accept a descriptor.
- `cmp_true`, input, 1: the compare unit `true` output for this branch.
- `is_jump`, input, 1: unconditional jump; `cmp_true` is ignored when set.
- `pred_taken`, input, 1: the fetch-time prediction.
- `pc`, input, WIDTH: PC of the branch instruction.
- `br_target`, input, WIDTH: computed taken target.
- `redirect_valid`, output, 1: a redirect request to fetch is pending.
- `redirect_pc`, output, WIDTH: the PC fetch must restart from.
- `redirect_ack`, input, 1: fetch accepts the redirect.
- `flush`, output, 1: one-cycle pulse that kills younger instructions in IF/ID.
- `exc_misalign`, output, 1: one-cycle pulse for a taken branch with a misaligned target.
- `exc_pc`, output, WIDTH: PC of the faulting branch, valid while `exc_misalign` is high.
- `taken_cnt`, output, 32: number of taken branches. Present only with `BR_PERF_CNT_EN`.
- `mispred_cnt`, output, 32: number of mispredictions. Present only with `BR_PERF_CNT_EN`.

## Operation
- The descriptor is accepted on an edge where `in_valid && in_ready`.
- `taken = is_jump | cmp_true`.
- `mispred = taken ^ pred_taken`.
- `fix_pc = taken ? br_target : pc + 4`. The addition is WIDTH bits and wraps modulo 2^WIDTH.
- Misalignment check: if `taken && br_target[1:0] != 0`:
  - `exc_misalign` pulses and `exc_pc` is set to `pc`.
  - No redirect is issued and no `flush` pulse is generated by this path.
  - The trap unit is responsible for the flush.
- Otherwise, if `mispred`:
  - `redirect_pc` is loaded with `fix_pc`.
  - The FSM enters REQ.
  - `flush` pulses.
- A correctly predicted, aligned branch produces no output activity.
- FSM states:
  - IDLE: `in_ready=1`, `redirect_valid=0`.
  - IDLE → REQ when a mispredicted, aligned descriptor is accepted.
  - REQ: `in_ready=0`, `redirect_valid=1`, and `redirect_pc` is held stable.
  - REQ → IDLE on `redirect_ack`.
  - `redirect_ack` is ignored in IDLE.
- In REQ, `in_valid` is stalled, not dropped. Upstream holds the descriptor.
- If `redirect_ack` and `in_valid` are high in the same REQ cycle, the ack is taken. The new descriptor is accepted no earlier than the following cycle (IDLE).
- All outputs are registered.

## Timing
- Descriptor accepted at edge N:
  - `redirect_valid`, `redirect_pc`, `flush`, `exc_misalign` and `exc_pc` are visible from edge N to edge N+1.
  - `flush` and `exc_misalign` are high for exactly that one cycle.
- `redirect_ack` sampled at edge M in REQ: `redirect_valid` is 0 and `in_ready` is 1 after edge M.
- The minimum redirect round trip is 2 cycles: accept, then ack in the next cycle.
- Throughput for non-redirecting branches is one per cycle.
- Reset values:
  - FSM in IDLE, so `in_ready=1` from reset.
  - `redirect_valid=0`, `redirect_pc=0`, `flush=0`, `exc_misalign=0`, `exc_pc=0`.
  - Counters 0.
- Reset asserted in REQ abandons the pending redirect immediately; no ack is required.

## Configuration
- `BR_PERF_CNT_EN` defined:
  - `taken_cnt` increments on each accepted descriptor with `taken=1`, including misaligned ones.
  - `mispred_cnt` increments on each accepted descriptor with `mispred=1`, including misaligned ones.
  - Both counters are 32 bits, wrap from 0xFFFFFFFF to 0, and clear on reset.
- `BR_PERF_CNT_EN` undefined: both ports and all counter logic are absent.
- The block's behaviour is otherwise identical in both builds.

## Test plan
- Not-taken, predicted not-taken: `pc=0x100`, `cmp_true=0`, `pred_taken=0`, `in_valid` for 1 cycle → no `flush`, `redirect_valid` stays 0, `in_ready` stays 1.
- Taken, predicted not-taken: `pc=0x100`, `br_target=0x200`, `cmp_true=1` at edge N → `flush` pulses in cycle N+1 only, and `redirect_valid=1` with `redirect_pc=0x200`. Hold `redirect_ack=0` for 3 cycles → `redirect_pc` is stable and `in_ready=0`. Ack → `redirect_valid=0` on the next edge.
- Not-taken, predicted taken, at the wrap boundary: `pc=0xFFFFFFFC`, `cmp_true=0`, `pred_taken=1` → `redirect_pc=0x00000000`.
- Misaligned jump: `is_jump=1`, `br_target=0x202`, `pc=0x80` → `exc_misalign` pulses 1 cycle with `exc_pc=0x80`, no `flush`, `redirect_valid=0`.
- Simultaneous events and reset: in REQ, assert `redirect_ack` and `in_valid` (a mispredicted branch) together → first request retires, the new one is accepted the next cycle and a second `flush` pulse follows. Then assert `reset` mid-REQ → `redirect_valid=0` and `in_ready=1` asynchronously.
- With `BR_PERF_CNT_EN`, send 5 branches: taken/pred pairs (1,1), (1,0), (0,1), (0,0), (1,1) → `taken_cnt=3`, `mispred_cnt=2`.
